// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared ES1 SPU operator helpers: saturation limits and the SLA overflow rule.
// Operands wider than 64 bits are outside the range these helpers cover.
package elixirchip_es1_spu_pkg;

  localparam int SPU_MAX_BITS = 64;
  typedef logic [SPU_MAX_BITS-1:0] spu_word_t;

  function automatic spu_word_t SAT_MAX(input int bits);
    return (spu_word_t'(64'd1) << (bits - 1)) - spu_word_t'(64'd1);
  endfunction

  function automatic spu_word_t SAT_MIN(input int bits);
    return spu_word_t'(64'd1) << (bits - 1);
  endfunction

  // data is zero-extended; the result overflows when the bits above the kept field differ from the sign
  function automatic logic spu_sla_overflow(input spu_word_t data, input int shift, input int bits);
    logic ovf;
    ovf = 1'b0;
    if (shift >= bits) begin
      ovf = |data;
    end else begin
      for (int i = 0; i < SPU_MAX_BITS; i++) begin
        if ((i < bits) && (i + shift >= bits - 1)) begin
          ovf = ovf | (data[i] ^ data[bits-1]);
        end else begin
          ovf = ovf;
        end
      end
    end
    return ovf;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// cke-gated delay line with synchronous reset; DEPTH=0 degenerates to a wire.
module elixirchip_es1_spu_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] m_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign m_data = s_data;
    end else begin : g_line
      logic [WIDTH-1:0] r_stage [DEPTH];

      // shift register advancing only on cke; reset flushes every stage
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= {WIDTH{1'b0}};
          end
        end else if (cke) begin
          r_stage[0] <= s_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end else begin
          r_stage <= r_stage;
        end
      end

      assign m_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_sla.sv
// Pipelined signed arithmetic shift left with overflow detection and sticky flag.
// Build option: ELIXIRCHIP_ES1_SPU_OP_SLA_SATURATE_EN replaces overflowing results by the saturated value.
module elixirchip_es1_spu_op_sla
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY         = 1,
  parameter int    DATA_BITS       = 8,
  parameter type   data_t          = logic [DATA_BITS-1:0],
  parameter int    MAX_SHIFT       = DATA_BITS,
  parameter int    SHIFT_BITS      = $clog2(MAX_SHIFT + 1),
  parameter type   shift_t         = logic [SHIFT_BITS-1:0],
  parameter data_t CLEAR_DATA      = {DATA_BITS{1'b0}},
  parameter bit    IMMEDIATE_SHIFT = 1'b0,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cke,
  input  shift_t s_shift,
  input  data_t  s_data,
  input  logic   s_clear,
  input  logic   s_valid,
  output data_t  m_data,
  output logic   m_overflow,
  output logic   m_overflow_sticky
);

  localparam int PIPE_BITS = DATA_BITS + 3;

  logic                 w_ovf;
  data_t                w_shifted;
  data_t                w_result;
  logic [PIPE_BITS-1:0] w_pipe_in;
  logic [PIPE_BITS-1:0] w_pipe_out;
  data_t                w_out_data;
  logic                 w_out_ovf;
  logic                 w_out_clear;
  logic                 w_out_valid;
  data_t                r_data;
  logic                 r_ovf;
  logic                 r_sticky;

  // raw shift, overflow detection and optional saturation
  always_comb begin
    w_ovf = spu_sla_overflow(64'(s_data), int'(s_shift), DATA_BITS);
    if (int'(s_shift) >= DATA_BITS) begin
      w_shifted = {DATA_BITS{1'b0}};
    end else begin
      w_shifted = s_data << s_shift;
    end
`ifdef ELIXIRCHIP_ES1_SPU_OP_SLA_SATURATE_EN
    if (w_ovf) begin
      w_result = s_data[DATA_BITS-1] ? data_t'(SAT_MIN(DATA_BITS)) : data_t'(SAT_MAX(DATA_BITS));
    end else begin
      w_result = w_shifted;
    end
`else
    w_result = w_shifted;
`endif
  end

  assign w_pipe_in = {w_result, w_ovf, s_clear, s_valid};

  // the first delay stage doubles as the registered compute stage when LATENCY>1
  generate
    if (LATENCY > 1) begin : g_delay
      elixirchip_es1_spu_delay #(
        .WIDTH (PIPE_BITS),
        .DEPTH (LATENCY - 1)
      ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .cke    (cke),
        .s_data (w_pipe_in),
        .m_data (w_pipe_out)
      );
    end else begin : g_direct
      assign w_pipe_out = w_pipe_in;
    end
  endgenerate

  assign {w_out_data, w_out_ovf, w_out_clear, w_out_valid} = w_pipe_out;

  // output stage: clear beats valid, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= CLEAR_DATA;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (cke && w_out_clear) begin
      r_data   <= CLEAR_DATA;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (cke && w_out_valid) begin
      r_data   <= w_out_data;
      r_ovf    <= w_out_ovf;
      r_sticky <= r_sticky | w_out_ovf;
    end else begin
      r_data   <= r_data;
      r_ovf    <= r_ovf;
      r_sticky <= r_sticky;
    end
  end

  assign m_data            = r_data;
  assign m_overflow        = r_ovf;
  assign m_overflow_sticky = r_sticky;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sla.sv
// Bench driving LATENCY=1 and LATENCY=3 instances with one shared stream, checked against an arithmetic model.
module tb_elixirchip_es1_spu_op_sla;

  typedef struct {
    logic [7:0] d;
    int         sh;
    bit         clr;
    bit         vld;
  } op_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cke;
  logic [3:0] sh;
  logic [7:0] d;
  logic       clr;
  logic       vld;

  logic [7:0] m1_data, m3_data;
  logic       m1_ovf, m3_ovf, m1_sticky, m3_sticky;

  int checks = 0;
  int errors = 0;

  op_t        q1[$];
  op_t        q3[$];
  logic [7:0] e_m [2];
  bit         e_o [2];
  bit         e_s [2];

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_sla #(.LATENCY(1), .DATA_BITS(8), .CLEAR_DATA(8'hFF)) u_l1 (
    .clk(clk), .reset(reset), .cke(cke), .s_shift(sh), .s_data(d),
    .s_clear(clr), .s_valid(vld),
    .m_data(m1_data), .m_overflow(m1_ovf), .m_overflow_sticky(m1_sticky)
  );

  elixirchip_es1_spu_op_sla #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(8'hFF)) u_l3 (
    .clk(clk), .reset(reset), .cke(cke), .s_shift(sh), .s_data(d),
    .s_clear(clr), .s_valid(vld),
    .m_data(m3_data), .m_overflow(m3_ovf), .m_overflow_sticky(m3_sticky)
  );

  // value = data * 2^shift; it overflows when outside the signed 8-bit range
  function automatic void ref_sla(input logic [7:0] dd, input int s, output logic [7:0] r, output bit o);
    longint v;
    v = longint'($signed(dd)) * (longint'(1) << s);
    o = (v > 127) || (v < -128);
    r = v[7:0];
`ifdef ELIXIRCHIP_ES1_SPU_OP_SLA_SATURATE_EN
    if (o) r = dd[7] ? 8'h80 : 8'h7F;
`endif
  endfunction

  task automatic apply(input int k, input op_t op);
    logic [7:0] r;
    bit o;
    if (op.clr) begin
      e_m[k] = 8'hFF; e_o[k] = 1'b0; e_s[k] = 1'b0;
    end else if (op.vld) begin
      ref_sla(op.d, op.sh, r, o);
      e_m[k] = r; e_o[k] = o; e_s[k] = e_s[k] | o;
    end
  endtask

  task automatic model_edge();
    op_t op;
    if (reset) begin
      q1.delete(); q3.delete();
      for (int k = 0; k < 2; k++) begin
        e_m[k] = 8'hFF; e_o[k] = 1'b0; e_s[k] = 1'b0;
      end
    end else if (cke) begin
      op.d = d; op.sh = int'(sh); op.clr = clr; op.vld = vld;
      q1.push_back(op);
      if (q1.size() == 1) apply(0, q1.pop_front());
      q3.push_back(op);
      if (q3.size() == 3) apply(1, q3.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("L1 m_data", m1_data, e_m[0]);
    chk("L1 m_overflow", {7'd0, m1_ovf}, {7'd0, e_o[0]});
    chk("L1 m_overflow_sticky", {7'd0, m1_sticky}, {7'd0, e_s[0]});
    chk("L3 m_data", m3_data, e_m[1]);
    chk("L3 m_overflow", {7'd0, m3_ovf}, {7'd0, e_o[1]});
    chk("L3 m_overflow_sticky", {7'd0, m3_sticky}, {7'd0, e_s[1]});
  endtask

  task automatic drive(input logic k, input logic [7:0] dd, input logic [3:0] s, input logic c, input logic v);
    cke = k; d = dd; sh = s; clr = c; vld = v;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 8'h00, 4'd0, 1'b0, 1'b0);
    cyc(); cyc();
    chk("reset L1 m_data", m1_data, 8'hFF);
    chk("reset L3 m_data", m3_data, 8'hFF);
    reset = 1'b0;

    drive(1'b1, 8'h05, 4'd2, 1'b0, 1'b1); cyc();
    chk("dir 05<<2", m1_data, 8'h14);
    drive(1'b1, 8'h40, 4'd1, 1'b0, 1'b1); cyc();
    chk("dir 40<<1 ovf", {7'd0, m1_ovf}, 8'h01);
    drive(1'b1, 8'h01, 4'd1, 1'b0, 1'b1); cyc();
    chk("dir sticky held", {7'd0, m1_sticky}, 8'h01);
    drive(1'b1, 8'hF0, 4'd3, 1'b0, 1'b1); cyc();
    chk("dir F0<<3", m1_data, 8'h80);
    drive(1'b1, 8'hF0, 4'd4, 1'b0, 1'b1); cyc();
    drive(1'b1, 8'h01, 4'd8, 1'b0, 1'b1); cyc();
    drive(1'b1, 8'h12, 4'd1, 1'b1, 1'b1); cyc();
    chk("dir clear", m1_data, 8'hFF);
    drive(1'b1, 8'h33, 4'd1, 1'b0, 1'b0); cyc(); cyc(); cyc(); cyc();

    // three ops issued, then a frozen pipe, then drain
    drive(1'b1, 8'h11, 4'd1, 1'b0, 1'b1); cyc();
    drive(1'b1, 8'h22, 4'd2, 1'b0, 1'b1); cyc();
    drive(1'b1, 8'hC3, 4'd1, 1'b0, 1'b1); cyc();
    drive(1'b0, 8'h7E, 4'd5, 1'b1, 1'b1); cyc(); cyc(); cyc(); cyc();
    drive(1'b1, 8'h00, 4'd0, 1'b0, 1'b0); cyc(); cyc(); cyc();

    // reset with two ops in flight
    drive(1'b1, 8'h03, 4'd1, 1'b0, 1'b1); cyc();
    drive(1'b1, 8'h04, 4'd1, 1'b0, 1'b1); cyc();
    reset = 1'b1; drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0); cyc();
    reset = 1'b0; drive(1'b1, 8'h00, 4'd0, 1'b0, 1'b0); cyc(); cyc(); cyc(); cyc();
    chk("no stale after reset", m3_data, 8'hFF);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) != 0, 8'($urandom), 4'($urandom_range(0, 8)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
